// File: rtl/contador_ctrl.sv
// rtl/contador_ctrl.sv - IDLE/RUN/PAUSE sequencer driving a two-digit BCD up/down counter
// Optional feature macro: CONTADOR_BLANK_EN (registered leading-zero blank request for tens digit)
module contador_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic       up_down,
  input  logic [7:0] load_val,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       wrap,
  output logic       load_err,
  output logic       tens_blank
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tick;
  logic          step;
  logic          load_ok;
  logic [3:0]    tens_d;
  logic [3:0]    ones_d;
  logic          wrap_d;
  logic          lerr_d;

  // A step is lost whenever a load, clear or stop lands on the terminal tick
  assign step    = (state == S_RUN) && (tick == TICK_LAST) && !clear && !load && !stop;
  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

  // State register
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state: clear dominates; stop outranks start in the same cycle
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_RUN;
        S_RUN:   if (stop) state_nx = S_PAUSE;
        S_PAUSE: begin
          if (stop)       state_nx = S_IDLE;
          else if (start) state_nx = S_RUN;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output decode of the state register
  always_comb begin
    running = (state == S_RUN);
  end

  // Tick divider: free-runs in RUN, holds in PAUSE (so resume keeps the partial interval)
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      tick <= '0;
    end else if (clear || load || state == S_IDLE || state_nx == S_IDLE) begin
      tick <= '0;
    end else if (state == S_RUN && !stop) begin
      tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
    end
  end

  // Next count value and event pulses: clear > load > step
  always_comb begin
    tens_d = bcd_tens;
    ones_d = bcd_ones;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (clear) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (load) begin
      if (load_ok) begin
        tens_d = load_val[7:4];
        ones_d = load_val[3:0];
      end else begin
        lerr_d = 1'b1;
      end
    end else if (step) begin
      if (up_down) begin
        if (bcd_ones >= 4'd9) begin
          ones_d = 4'd0;
          if (bcd_tens >= 4'd9) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = bcd_tens + 4'd1;
          end
        end else begin
          ones_d = bcd_ones + 4'd1;
        end
      end else begin
        if (bcd_ones == 4'd0) begin
          ones_d = 4'd9;
          if (bcd_tens == 4'd0) begin
            tens_d = 4'd9;
            wrap_d = 1'b1;
          end else begin
            tens_d = bcd_tens - 4'd1;
          end
        end else begin
          ones_d = bcd_ones - 4'd1;
        end
      end
    end
  end

  // Count and one-cycle event registers
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      bcd_tens <= tens_d;
      bcd_ones <= ones_d;
      wrap     <= wrap_d;
      load_err <= lerr_d;
    end
  end

`ifdef CONTADOR_BLANK_EN
  // Blank request follows the tens digit on the same edge it is written
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) tens_blank <= 1'b1;
    else       tens_blank <= (tens_d == 4'd0);
  end
`else
  assign tens_blank = 1'b0;
`endif

endmodule

// File: tb/tb_contador_ctrl.sv
// tb/tb_contador_ctrl.sv - scoreboard bench for contador_ctrl against a decimal reference model
module tb_contador_ctrl;

  localparam int DIV = 4;
`ifdef CONTADOR_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, up_down = 1'b1;
  logic [7:0] load_val = 8'h00;
  logic [3:0] bcd_tens, bcd_ones;
  logic       running, wrap, load_err, tens_blank;

  contador_ctrl #(.TICK_DIV(DIV)) dut (
    .CLOCK_50  (clk),
    .KEY0      (rst_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .load      (load),
    .up_down   (up_down),
    .load_val  (load_val),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .running   (running),
    .wrap      (wrap),
    .load_err  (load_err),
    .tens_blank(tens_blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tens;
    int ones;
    int run;
    int wrp;
    int lerr;
    int blank;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: 0=idle 1=run 2=pause, count kept as an integer 0..99
  int m_state = 0;
  int m_count = 0;
  int m_tick  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit st, input bit sp, input bit cl, input bit ld,
                       input bit ud, input logic [7:0] lv);
    exp_t e;
    int   nst;
    bit   do_step;
    int   lt, lo;
    e.wrp  = 0;
    e.lerr = 0;
    if (cl) begin
      m_state = 0;
      m_count = 0;
      m_tick  = 0;
    end else begin
      do_step = (m_state == 1) && !ld && !sp && (m_tick == DIV - 1);
      nst = m_state;
      if (m_state == 0 && st) nst = 1;
      else if (m_state == 1 && sp) nst = 2;
      else if (m_state == 2 && sp) nst = 0;
      else if (m_state == 2 && st) nst = 1;
      if (ld || m_state == 0 || nst == 0) m_tick = 0;
      else if (m_state == 1 && !sp) m_tick = (m_tick + 1) % DIV;
      if (ld) begin
        lt = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (lt > 9 || lo > 9) e.lerr = 1;
        else m_count = lt * 10 + lo;
      end else if (do_step) begin
        if (ud) begin
          if (m_count == 99) e.wrp = 1;
          m_count = (m_count + 1) % 100;
        end else begin
          if (m_count == 0) e.wrp = 1;
          m_count = (m_count + 99) % 100;
        end
      end
      m_state = nst;
    end
    e.tens  = m_count / 10;
    e.ones  = m_count % 10;
    e.run   = (m_state == 1) ? 1 : 0;
    e.blank = (BLANK && (m_count / 10 == 0)) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit sp, input bit cl, input bit ld,
                     input bit ud, input logic [7:0] lv);
    @(negedge clk);
    start = st; stop = sp; clear = cl; load = ld; up_down = ud; load_val = lv;
    model(st, sp, cl, ld, ud, lv);
    @(posedge clk);
    #2;
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int n, input bit ud);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ud, 8'h00);
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_tens"},  int'(bcd_tens), 0);
    check({tag, "_ones"},  int'(bcd_ones), 0);
    check({tag, "_run"},   int'(running), 0);
    check({tag, "_wrap"},  int'(wrap), 0);
    check({tag, "_lerr"},  int'(load_err), 0);
    check({tag, "_blank"}, int'(tens_blank), int'(BLANK));
    m_state = 0;
    m_count = 0;
    m_tick  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one registered output set per clock, compared against the queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("tens",  int'(bcd_tens),   e.tens);
        check("ones",  int'(bcd_ones),   e.ones);
        check("run",   int'(running),    e.run);
        check("wrap",  int'(wrap),       e.wrp);
        check("lerr",  int'(load_err),   e.lerr);
        check("blank", int'(tens_blank), e.blank);
      end
    end
  end

  initial begin : stim
    bit         st, sp, cl, ld, ud;
    int         r;
    logic [7:0] lv;
    #3;
    reset_check("por");

    // count up from reset
    cyc(1, 0, 0, 0, 1, 8'h00);
    idle(9, 1);
    // wrap upward from 98
    cyc(0, 1, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h98);
    cyc(1, 0, 0, 0, 1, 8'h00);
    idle(12, 1);
    // wrap downward from 00
    cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    idle(10, 0);
    // loads while paused
    cyc(0, 1, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h3A);
    cyc(0, 0, 0, 1, 1, 8'h47);
    cyc(0, 0, 0, 1, 1, 8'hA2);
    // pause mid-interval, resume, then halt
    cyc(0, 0, 1, 0, 1, 8'h00);
    cyc(1, 0, 0, 0, 1, 8'h00);
    idle(2, 1);
    cyc(0, 1, 0, 0, 1, 8'h00);
    idle(10, 1);
    cyc(1, 0, 0, 0, 1, 8'h00);
    idle(4, 1);
    cyc(0, 1, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 0, 1, 8'h00);
    // clear+load on terminal tick
    cyc(0, 0, 0, 1, 1, 8'h99);
    cyc(1, 0, 0, 0, 1, 8'h00);
    idle(3, 1);
    cyc(0, 0, 1, 1, 1, 8'h55);
    // asynchronous reset mid-run
    cyc(0, 0, 0, 1, 1, 8'h73);
    cyc(1, 0, 0, 0, 1, 8'h00);
    idle(6, 1);
    reset_check("midrun");

    // randomized traffic
    ud = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      st = (r < 10);
      sp = (r >= 10 && r < 16);
      cl = (r == 99);
      ld = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) ud = ~ud;
      lv[7:4] = 4'($urandom_range(0, 11));
      lv[3:0] = 4'($urandom_range(0, 11));
      cyc(st, sp, cl, ld, ud, lv);
    end
    reset_check("final");

    check("queue_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
